// File: rtl/sampler_trigger.sv
// Trigger stage in front of the sampler memory: registers probed data and holds
// the sampler in reset until a mask/value (level or edge) or forced trigger plus delay.
module sampler_trigger #(
  parameter int WIDTH      = 32,
  parameter int DELAY_BITS = 16
) (
  input  logic                  w_clk,
  input  logic                  w_reset_n,
  input  logic [WIDTH-1:0]      d_in,
  input  logic [WIDTH-1:0]      trig_mask,
  input  logic [WIDTH-1:0]      trig_value,
  input  logic                  trig_edge,
  input  logic [DELAY_BITS-1:0] trig_delay,
  input  logic                  trig_force,
  output logic [WIDTH-1:0]      d_out,
  output logic                  s_reset_n,
  output logic                  triggered,
  output logic [1:0]            state
);

  // ST_DLY doubles as RUN once r_run is set; CSR readback sees 3 for both.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DLY  = 2'd3
  } state_t;

  localparam logic [DELAY_BITS-1:0] CNT_ZERO = {DELAY_BITS{1'b0}};
  localparam logic [DELAY_BITS-1:0] CNT_ONE  = {{(DELAY_BITS-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_run;
  logic                  w_run_nxt;
  logic [DELAY_BITS-1:0] r_cnt;
  logic [DELAY_BITS-1:0] w_cnt_nxt;
  logic                  r_prev_match;
  logic                  w_prev_match_nxt;
  logic [WIDTH-1:0]      r_d_q;
  logic [WIDTH-1:0]      r_d_out;
  logic                  r_s_reset_n;
  logic                  r_triggered;
  logic                  w_match;
  logic                  w_trig;

  assign w_match = (((r_d_q ^ trig_value) & trig_mask) == {WIDTH{1'b0}});
  assign w_trig  = trig_force | (trig_edge ? (w_match & ~r_prev_match) : w_match);

  // Two-stage data pipe; the trigger decision is made on r_d_q.
  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      r_d_q   <= {WIDTH{1'b0}};
      r_d_out <= {WIDTH{1'b0}};
    end else begin
      r_d_q   <= d_in;
      r_d_out <= r_d_q;
    end
  end

  // FSM state, delay counter, match history and registered sampler controls.
  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_cnt        <= CNT_ZERO;
      r_prev_match <= 1'b0;
      r_s_reset_n  <= 1'b0;
      r_triggered  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= w_run_nxt;
      r_cnt        <= w_cnt_nxt;
      r_prev_match <= w_prev_match_nxt;
      // Driven from next state so s_reset_n rises together with d_out holding the trigger sample.
      r_s_reset_n  <= w_run_nxt;
      r_triggered  <= (w_state_nxt == ST_DLY);
    end
  end

  // Next-state logic; ARM only seeds match history so edge mode cannot fire on stale data.
  always_comb begin
    w_state_nxt      = r_state;
    w_run_nxt        = r_run;
    w_cnt_nxt        = r_cnt;
    w_prev_match_nxt = r_prev_match;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_prev_match_nxt = w_match;
        w_state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        w_prev_match_nxt = w_match;
        if (w_trig) begin
          w_cnt_nxt   = trig_delay;
          w_state_nxt = ST_DLY;
          w_run_nxt   = (trig_delay == CNT_ZERO);
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DLY: begin
        if (!r_run) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          w_run_nxt = (r_cnt == CNT_ONE);
        end else begin
          w_cnt_nxt = CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign d_out     = r_d_out;
  assign s_reset_n = r_s_reset_n;
  assign triggered = r_triggered;
  assign state     = r_state;

endmodule
